// File: rtl/pp_compressor_pkg.sv
// Shared sizing helpers for the pipelined Booth partial-product compressor.
// All tree and pipeline geometry is derived here at elaboration time.
package pp_compressor_pkg;

  localparam logic ZERO_BIT = 1'b0;

  function automatic int num_pp(int w);
    return w / 2 + 1;
  endfunction

  function automatic int row_w(int w);
    return w + 2;
  endfunction

  function automatic int out_w(int w, int g);
    return 2 * w + g;
  endfunction

  function automatic int csa_next(int rows);
    return (rows / 3) * 2 + rows % 3;
  endfunction

  function automatic int csa_levels(int rows);
    int n;
    int l;
    n = rows;
    l = 0;
    while (n > 2) begin
      n = csa_next(n);
      l++;
    end
    return l;
  endfunction

  function automatic int rows_at(int rows, int lvl);
    int n;
    n = rows;
    for (int i = 0; i < lvl; i++)
      n = csa_next(n);
    return n;
  endfunction

  // Internal ranks sit after level floor(r*levels/stages), r = 1..stages-1.
  function automatic bit rank_at(int lvl, int levels, int stages);
    for (int r = 1; r < stages; r++)
      if (r * levels / stages == lvl) return 1'b1;
    return 1'b0;
  endfunction

endpackage

// File: rtl/pp_compressor_pipe_csa.sv
// Parametrised 3:2 carry-save adder.
// Carry is pre-shifted so carry+sum equals a+b+c mod 2^W.
module pp_compressor_pipe_csa
  import pp_compressor_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] carry,
  output logic [W-1:0] sum
);

  assign sum = a ^ b ^ c;

  assign carry = {
    (a[W-2:0] & b[W-2:0]) |
    (a[W-2:0] & c[W-2:0]) |
    (b[W-2:0] & c[W-2:0]),
    ZERO_BIT
  };

endmodule

// File: rtl/pp_compressor_pipe.sv
// Pipelined Booth partial-product compressor with carry-save accumulate.
// CSA tree with evenly spread ranks; the output rank is the accumulator.
module pp_compressor_pipe
  import pp_compressor_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int GUARD       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [num_pp(WIDTH)*row_w(WIDTH)-1:0] in_pp,
  input  logic [num_pp(WIDTH)-2:0] in_neg,
  input  logic in_acc,
  output logic out_valid,
  input  logic out_ready,
  output logic [out_w(WIDTH, GUARD)-1:0] out_c,
  output logic [out_w(WIDTH, GUARD)-1:0] out_s
);

  localparam int NUM_PP = num_pp(WIDTH);
  localparam int ROW_W  = row_w(WIDTH);
  localparam int OUT_W  = out_w(WIDTH, GUARD);
  localparam int NR0    = NUM_PP + 1;
  localparam int LEVELS = csa_levels(NR0);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [OUT_W-1:0] rows0 [NR0];

  always_comb begin
    for (int k = 0; k < NUM_PP; k++)
      rows0[k] = {{(OUT_W-ROW_W){in_pp[k*ROW_W+ROW_W-1]}},
                  in_pp[k*ROW_W +: ROW_W]} << (2 * k);
    rows0[NR0-1] = '0;
    for (int k = 0; k < NUM_PP - 1; k++)
      rows0[NR0-1][2*k] = in_neg[k];
  end

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int NI = rows_at(NR0, l);
    logic [OUT_W-1:0] d [NI];
    logic [OUT_W-1:0] n [NI];
    logic v, a, nv, na;

    if (l == 0) begin : g_src
      assign n  = rows0;
      assign nv = in_valid;
      assign na = in_acc;
    end else begin : g_csa
      localparam int NP = rows_at(NR0, l - 1);
      localparam int NG = NP / 3;
      localparam int NR = NP % 3;
      for (genvar j = 0; j < NG; j++) begin : g_grp
        pp_compressor_pipe_csa #(.W(OUT_W)) u_csa (
          .a     (g_lvl[l-1].d[3*j]),
          .b     (g_lvl[l-1].d[3*j+1]),
          .c     (g_lvl[l-1].d[3*j+2]),
          .carry (n[2*j]),
          .sum   (n[2*j+1])
        );
      end
      for (genvar t = 0; t < NR; t++) begin : g_pass
        assign n[2*NG+t] = g_lvl[l-1].d[3*NG+t];
      end
      assign nv = g_lvl[l-1].v;
      assign na = g_lvl[l-1].a;
    end

    if (rank_at(l, LEVELS, PIPE_STAGES)) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v <= 1'b0;
          a <= 1'b0;
          for (int i = 0; i < NI; i++)
            d[i] <= '0;
        end else if (adv) begin
          v <= nv;
          a <= na;
          for (int i = 0; i < NI; i++)
            d[i] <= n[i];
        end
      end
    end else begin : g_wire
      assign d = n;
      assign v = nv;
      assign a = na;
    end
  end

  logic [OUT_W-1:0] fb_c, fb_s, c1, s1, c2, s2;

  // A fresh total simply folds in zero instead of the previous result.
  assign fb_c = g_lvl[LEVELS].a ? out_c : '0;
  assign fb_s = g_lvl[LEVELS].a ? out_s : '0;

  pp_compressor_pipe_csa #(.W(OUT_W)) u_acc0 (
    .a     (g_lvl[LEVELS].d[0]),
    .b     (g_lvl[LEVELS].d[1]),
    .c     (fb_c),
    .carry (c1),
    .sum   (s1)
  );

  pp_compressor_pipe_csa #(.W(OUT_W)) u_acc1 (
    .a     (c1),
    .b     (s1),
    .c     (fb_s),
    .carry (c2),
    .sum   (s2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_c     <= '0;
      out_s     <= '0;
    end else if (adv) begin
      out_valid <= g_lvl[LEVELS].v;
      if (g_lvl[LEVELS].v) begin
        out_c <= c2;
        out_s <= s2;
      end
    end
  end

endmodule

// File: tb/tb_pp_compressor_pipe.sv
// Directed and randomised checks of pp_compressor_pipe.
// WIDTH=8/PIPE_STAGES=2 directed; WIDTH=32 at 1 and 4 stages vs a model.
module tb_pp_compressor_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [49:0] pp8;
  logic [3:0]  neg8;
  logic        iv8, acc8, ir8, ov8, or8;
  logic [19:0] c8, s8, sum8;
  assign sum8 = c8 + s8;

  pp_compressor_pipe #(.WIDTH(8), .PIPE_STAGES(2), .GUARD(4)) u8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .in_pp     (pp8),
    .in_neg    (neg8),
    .in_acc    (acc8),
    .out_valid (ov8),
    .out_ready (or8),
    .out_c     (c8),
    .out_s     (s8)
  );

  logic [577:0] pp32;
  logic [15:0]  neg32;
  logic         iv32, acc32, or32;
  logic         ir1, ov1, ir4, ov4;
  logic [67:0]  c1, s1, c4, s4, sum1, sum4;
  assign sum1 = c1 + s1;
  assign sum4 = c4 + s4;

  pp_compressor_pipe #(.WIDTH(32), .PIPE_STAGES(1), .GUARD(4)) u32a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv32),
    .in_ready  (ir1),
    .in_pp     (pp32),
    .in_neg    (neg32),
    .in_acc    (acc32),
    .out_valid (ov1),
    .out_ready (or32),
    .out_c     (c1),
    .out_s     (s1)
  );

  pp_compressor_pipe #(.WIDTH(32), .PIPE_STAGES(4), .GUARD(4)) u32b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv32),
    .in_ready  (ir4),
    .in_pp     (pp32),
    .in_neg    (neg32),
    .in_acc    (acc32),
    .out_valid (ov4),
    .out_ready (or32),
    .out_c     (c4),
    .out_s     (s4)
  );

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [67:0] obs,
                     input logic [67:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [49:0] one_row(input int k, input logic [9:0] v);
    logic [49:0] t;
    t = '0;
    t[k*10 +: 10] = v;
    return t;
  endfunction

  function automatic logic [67:0] mv(input logic [577:0] pp,
                                     input logic [15:0] ng);
    logic [67:0] t;
    logic [33:0] r;
    logic [67:0] e;
    t = '0;
    for (int k = 0; k < 17; k++) begin
      r = pp[k*34 +: 34];
      e = {{34{r[33]}}, r};
      t = t + (e << (2 * k));
    end
    for (int k = 0; k < 16; k++)
      t = t + (68'(ng[k]) << (2 * k));
    return t;
  endfunction

  logic [9:0]  bp_v [3] = '{10'd1, 10'd2, 10'd3};
  logic        bp_a [3] = '{1'b0, 1'b1, 1'b1};
  logic [19:0] bp_e [3] = '{20'd1, 20'd3, 20'd6};
  int          bi, ri;
  logic        saw_low;

  logic [67:0] q [$];
  logic [67:0] tot, v32;
  logic [63:0] rr;
  int          n1, n4, nb;

  initial begin
    rst = 1'b1;
    pp8 = '0; neg8 = '0; iv8 = 1'b0; acc8 = 1'b0; or8 = 1'b1;
    pp32 = '0; neg32 = '0; iv32 = 1'b0; acc32 = 1'b0; or32 = 1'b1;
    tick;
    tick;
    chk("rst_ov", 68'(ov8), 68'd0);
    chk("rst_c", 68'(c8), 68'd0);
    chk("rst_s", 68'(s8), 68'd0);
    chk("rst_ir", 68'(ir8), 68'd1);
    rst = 1'b0;
    tick;

    pp8 = one_row(0, 10'd1); iv8 = 1'b1;
    #1;
    chk("single_ir", 68'(ir8), 68'd1);
    tick;
    iv8 = 1'b0;
    chk("single_early", 68'(ov8), 68'd0);
    tick;
    chk("single_ov", 68'(ov8), 68'd1);
    chk("single_sum", 68'(sum8), 68'd1);
    tick;
    chk("single_once", 68'(ov8), 68'd0);

    pp8 = one_row(0, 10'h3FF) | one_row(1, 10'd2);
    neg8 = 4'b0001; iv8 = 1'b1;
    tick;
    iv8 = 1'b0; neg8 = '0;
    tick;
    chk("signed_ov", 68'(ov8), 68'd1);
    chk("signed_sum", 68'(sum8), 68'd8);

    pp8 = one_row(4, 10'h3FF); iv8 = 1'b1;
    tick;
    iv8 = 1'b0;
    tick;
    chk("neg_sum", 68'(sum8), 68'hFFF00);

    pp8 = one_row(0, 10'd100); acc8 = 1'b0; iv8 = 1'b1;
    tick;
    pp8 = one_row(0, 10'd23); acc8 = 1'b1;
    tick;
    chk("acc_a", 68'(sum8), 68'd100);
    pp8 = one_row(0, 10'd5); acc8 = 1'b0;
    tick;
    chk("acc_b", 68'(sum8), 68'd123);
    iv8 = 1'b0;
    tick;
    chk("acc_c_ov", 68'(ov8), 68'd1);
    chk("acc_c", 68'(sum8), 68'd5);
    tick;

    bi = 0; ri = 0; saw_low = 1'b0;
    for (int cyc = 0; cyc < 20 && ri < 3; cyc++) begin
      or8  = (cyc >= 5);
      iv8  = (bi < 3);
      pp8  = one_row(0, bp_v[bi < 3 ? bi : 2]);
      acc8 = bp_a[bi < 3 ? bi : 2];
      #1;
      if (!ir8) saw_low = 1'b1;
      if (cyc == 4) chk("bp_hold", 68'(sum8), 68'd1);
      if (ov8 && or8) begin
        chk("bp_res", 68'(sum8), 68'(bp_e[ri]));
        ri++;
      end
      if (iv8 && ir8) bi++;
      tick;
    end
    iv8 = 1'b0; or8 = 1'b1;
    chk("bp_stall_seen", 68'(saw_low), 68'd1);
    chk("bp_in_cnt", 68'(bi), 68'd3);
    chk("bp_out_cnt", 68'(ri), 68'd3);
    chk("bp_drain", 68'(ov8), 68'd0);

    or8 = 1'b0; pp8 = one_row(0, 10'd9); acc8 = 1'b0; iv8 = 1'b1;
    tick;
    tick;
    iv8 = 1'b0;
    chk("mid_full_ov", 68'(ov8), 68'd1);
    chk("mid_full_ir", 68'(ir8), 68'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", 68'(ov8), 68'd0);
    chk("mid_rst_ir", 68'(ir8), 68'd1);
    chk("mid_rst_sum", 68'(sum8), 68'd0);
    tick;
    rst = 1'b0; or8 = 1'b1;
    pp8 = one_row(0, 10'd7); acc8 = 1'b1; iv8 = 1'b1;
    tick;
    iv8 = 1'b0; acc8 = 1'b0;
    tick;
    chk("mid_ov", 68'(ov8), 68'd1);
    chk("mid_sum", 68'(sum8), 68'd7);
    tick;
    chk("mid_flushed", 68'(ov8), 68'd0);

    tot = '0; n1 = 0; n4 = 0; nb = 0;
    for (int i = 0; i < 1010; i++) begin
      for (int k = 0; k < 17; k++) begin
        rr = {$urandom(), $urandom()};
        pp32[k*34 +: 34] = rr[33:0];
      end
      neg32 = 16'($urandom());
      acc32 = 1'($urandom_range(1));
      iv32  = (i < 1000) && ($urandom_range(3) != 0);
      if (iv32) begin
        v32 = mv(pp32, neg32);
        tot = acc32 ? tot + v32 : v32;
        q.push_back(tot);
        nb++;
      end
      tick;
      if (ov1) begin
        if (n1 < q.size()) chk("w32_p1", sum1, q[n1]);
        else chk("w32_p1_extra", 68'(n1), 68'(q.size()));
        n1++;
      end
      if (ov4) begin
        if (n4 < q.size()) chk("w32_p4", sum4, q[n4]);
        else chk("w32_p4_extra", 68'(n4), 68'(q.size()));
        n4++;
      end
    end
    chk("w32_p1_cnt", 68'(n1), 68'(nb));
    chk("w32_p4_cnt", 68'(n4), 68'(nb));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/pp_compressor_pipe.md
Name: pp_compressor_pipe

Overview:
- Parametrised, pipelined successor to the fixed 32-bit Booth partial-product compressor.
- Reduces NUM_PP radix-4 Booth rows of any even operand WIDTH, plus their negation-correction bits, to a carry/sum pair.
- Has a valid/ready handshake with backpressure and an optional accumulate mode that folds each beat into a running carry-save total, giving MAC use.
- Sits between the Booth encoder and the final carry-propagate adder.

Parameters:
- WIDTH, 32: operand width; even, 8..64. Derived: NUM_PP = WIDTH/2+1, ROW_W = WIDTH+2.
- PIPE_STAGES, 2: register ranks including the output rank; 1..4. Latency equals PIPE_STAGES.
- GUARD, 4: extra accumulator MSBs. Derived: OUT_W = 2*WIDTH+GUARD.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_pp  in  NUM_PP*ROW_W  row k at bits [k*ROW_W +: ROW_W]; two's complement
- in_neg  in  NUM_PP-1  Booth negation bit k, weight 2^(2k)
- in_acc  in  1  1 = add beat to running total; 0 = start a new total
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_c  out  OUT_W  carry vector, already aligned (no further shift)
- out_s  out  OUT_W  sum vector

Behaviour:
- Arithmetic. Beat value V = sum over k of sext(row k) * 2^(2k), plus sum over k of in_neg[k] * 2^(2k), taken mod 2^OUT_W.
- Output register. If in_acc=0: out_c+out_s ≡ V. If in_acc=1: out_c+out_s ≡ V + previous (out_c+out_s). All equivalences are mod 2^OUT_W; only the sum is defined, not the individual vectors.
- Tree. 3:2 CSA layers, depth determined at elaboration from NUM_PP. In accumulate mode the two accumulator rows enter through two extra CSA layers before the output rank.
- Registers. PIPE_STAGES-1 internal ranks, spread as evenly as possible across tree levels. The output rank is the accumulator.
- Flow control. adv = !out_valid || out_ready. in_ready = adv, combinational.
- On adv, every rank shifts: data plus valid bit and in_acc tag. When adv=0 all ranks hold.
- The accumulator (out_c/out_s) updates only when adv=1 and the last internal stage is valid. Bubbles leave it and its contents unchanged and set out_valid=0.
- out_valid follows the valid bit shifted into the output rank. A result is presented exactly once per accepted beat.
- Latency: a beat accepted at edge n appears at edge n+PIPE_STAGES-1 when there are no stalls; i.e. out_valid rises PIPE_STAGES-1 edges after acceptance (same edge as acceptance when PIPE_STAGES=1).
- Accumulator dependence. in_acc=1 refers to the immediately preceding valid beat in order, which is always the value in the output rank at that moment. No hazard exists, because the only rank that reads the feedback is the output rank.
- Overflow. Wraps mod 2^OUT_W silently; no saturation and no flag.
- Reset (async, any time, including mid-stall). Clears all valid bits, out_c, out_s and the accumulator to 0. in_ready=1 during and after reset. Beats in flight are discarded.
- First beat after reset with in_acc=1: adds to 0, so the result equals V.
- X on in_pp/in_neg while in_valid=0 must not propagate into the accumulator.

Decomposition:
- Package pp_compressor_pkg: functions num_pp(WIDTH), row_w(WIDTH), out_w(WIDTH, GUARD), csa_levels(rows); a local ZERO_BIT constant.
- Leaf sub-module: the existing CSA (parametrised 3:2 carry-save adder), reused for every layer.
- Tree generate loops and pipeline ranks stay in this module.

Test Plan:
- Reset. rst pulse, WIDTH=8 (NUM_PP=5, ROW_W=10, OUT_W=20) -> out_valid=0, out_c=out_s=0, in_ready=1.
- Single beat. pp0=1, other rows 0, in_neg=0, in_acc=0, PIPE_STAGES=2 -> out_valid=1 exactly one edge after acceptance; (out_c+out_s) mod 2^20 = 1.
- Signed rows. pp0=10'h3FF (-1), pp1=2, in_neg[0]=1, in_acc=0 -> sum = -1+8+1 = 8.
- Same bench, negative result. pp4=10'h3FF (-256), others 0 -> sum = 20'hFFF00.
- Accumulate. Beat A with V=100, in_acc=0; then beat B with V=23, in_acc=1; then beat C with V=5, in_acc=0 -> results 100, 123, 5 in order.
- Backpressure. out_ready=0 for 5 cycles while offering 3 back-to-back accumulating beats (V=1,2,3, first with in_acc=0) -> in_ready drops once all ranks are full. No beat lost or duplicated. Results are 1, 3, 6. Accumulator held during the stall.
- Reset mid-operation. rst asserted with the pipeline full and out_ready=0 -> out_valid=0 immediately. Next beat V=7 with in_acc=1 -> result 7.
- Width sweep. WIDTH=32, PIPE_STAGES=1 and 4, 1000 random beats -> every (out_c+out_s) matches a software model mod 2^68.
